// File: rtl/cpu_pkg.sv
// Shared types for the fetch path: cache FSM states and address-split constants.
package cpu_pkg;

    typedef enum logic [0:0] {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } icache_state_t;

    localparam int WORD_OFF_BITS = 2;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and backing-memory signals of the instruction cache, bundled as one bus.
interface icache_direct_if;
    logic [31:0] PCaddr;
    logic        flush;
    logic        iready;
    logic [31:0] instr;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // slave: the cache itself; master: the PC/memory environment around it
    modport slave  (input  PCaddr, flush, mem_rdata, mem_ready,
                    output iready, instr, mem_ren, mem_addr);
    modport master (output PCaddr, flush, mem_rdata, mem_ready,
                    input  iready, instr, mem_ren, mem_addr);
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data storage for the direct-mapped icache: one write port,
// combinational read by index, synchronous clear of every valid bit.
module icache_store #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic                  flush_all
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi] <= 1'b0;
                end else if (flush_all) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, single-word-line instruction cache with miss fill and fill forwarding.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
    import cpu_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic               clk,
    input  logic               nRST,
    icache_direct_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int WORD_BITS = 32 - WORD_OFF_BITS;
    localparam int TAG_BITS  = WORD_BITS - INDEX_BITS;

    icache_state_t          state_reg, state_next;
    logic [WORD_BITS-1:0]   fill_word_reg, fill_word_next;
    logic                   flush_pend_reg, flush_pend_next;

    logic [WORD_BITS-1:0]   pc_word;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [31:0]            rd_data;
    logic                   hit;
    logic                   wr_en;
    logic                   flush_all;
    logic                   iready;
    logic [31:0]            instr;
    logic                   mem_ren;
    logic [31:0]            mem_addr;

    assign pc_word = bus.PCaddr[31:WORD_OFF_BITS];
    assign hit     = rd_valid && (rd_tag == pc_word[WORD_BITS-1:INDEX_BITS]);

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk       (clk),
        .nRST      (nRST),
        .rd_idx    (pc_word[INDEX_BITS-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (fill_word_reg[INDEX_BITS-1:0]),
        .wr_tag    (fill_word_reg[WORD_BITS-1:INDEX_BITS]),
        .wr_data   (bus.mem_rdata),
        .flush_all (flush_all)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IC_IDLE;
            fill_word_reg  <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fill_word_reg  <= fill_word_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fill_word_next  = fill_word_reg;
        flush_pend_next = flush_pend_reg;
        iready          = 1'b0;
        instr           = '0;
        mem_ren         = 1'b0;
        mem_addr        = '0;
        wr_en           = 1'b0;
        flush_all       = 1'b0;
        case (state_reg)
            IC_IDLE: begin
                if (bus.flush) begin
                    flush_all = 1'b1;
                end else if (hit) begin
                    iready = 1'b1;
                    instr  = rd_data;
                end else begin
                    fill_word_next = pc_word;
                    state_next     = IC_FILL;
                end
            end
            IC_FILL: begin
                mem_ren  = 1'b1;
                mem_addr = {fill_word_reg, {WORD_OFF_BITS{1'b0}}};
                if (bus.mem_ready) begin
                    state_next      = IC_IDLE;
                    flush_pend_next = 1'b0;
                    // A flush seen at any point of the fill poisons the returned word.
                    if (bus.flush || flush_pend_reg) begin
                        flush_all = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (pc_word == fill_word_reg) begin
                            iready = 1'b1;
                            instr  = bus.mem_rdata;
                        end
                    end
                end else if (bus.flush) begin
                    flush_pend_next = 1'b1;
                end
            end
            default: begin
                state_next = IC_IDLE;
            end
        endcase
    end

    assign bus.iready   = iready;
    assign bus.instr    = instr;
    assign bus.mem_ren  = mem_ren;
    assign bus.mem_addr = mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_reg, miss_count_reg;
    logic        hit_evt, miss_evt;

    // Forwarded words arrive in FILL, so only IDLE hits count as hits.
    assign hit_evt  = (state_reg == IC_IDLE) && iready;
    assign miss_evt = (state_reg == IC_IDLE) && (state_next == IC_FILL);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_evt)  hit_count_reg  <= hit_count_reg + 32'd1;
            if (miss_evt) miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus a randomized run
// against a word-address-level model of cache contents and the outstanding fill.
module tb_icache_direct;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_direct #(.INDEX_BITS(4)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: which word address each line holds, plus the outstanding fill.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    bit          m_busy;
    bit          m_pend;
    logic [29:0] m_fill;
    int unsigned m_hits, m_misses;

    logic        o_iready, o_ren;
    logic [31:0] o_instr, o_addr;

    function automatic logic [31:0] memfn(input logic [29:0] w);
        if (w == 30'd0) return 32'h0050_0093;
        return (32'(w) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic [31:0] pc, input bit fl, input bit rdy);
        logic [29:0] w;
        int          idx;
        bit          hit, fwd;
        logic        e_ir, e_ren;
        logic [31:0] e_instr, e_addr;
        @(negedge clk);
        bus.PCaddr    = pc;
        bus.flush     = fl;
        bus.mem_ready = rdy;
        bus.mem_rdata = m_busy ? memfn(m_fill) : $urandom();
        #1;
        w   = pc[31:2];
        idx = int'(w[3:0]);
        hit = !m_busy && !fl && m_valid[idx] && (m_word[idx] == w);
        fwd = m_busy && rdy && !fl && !m_pend && (w == m_fill);
        e_ir    = hit || fwd;
        e_instr = e_ir ? memfn(w) : 32'd0;
        e_ren   = m_busy;
        e_addr  = m_busy ? {m_fill, 2'b00} : 32'd0;
        o_iready = bus.iready;
        o_instr  = bus.instr;
        o_ren    = bus.mem_ren;
        o_addr   = bus.mem_addr;
        check("iready",   32'(o_iready), 32'(e_ir));
        check("instr",    o_instr,       e_instr);
        check("mem_ren",  32'(o_ren),    32'(e_ren));
        check("mem_addr", o_addr,        e_addr);
`ifdef ICACHE_STATS_EN
        check("hit_count",  hit_count,  m_hits);
        check("miss_count", miss_count, m_misses);
`endif
        @(posedge clk);
        if (!m_busy) begin
            if (fl) model_clear();
            else if (hit) m_hits++;
            else begin
                m_busy = 1'b1;
                m_fill = w;
                m_misses++;
            end
        end else if (rdy) begin
            if (fl || m_pend) model_clear();
            else begin
                m_valid[int'(m_fill[3:0])] = 1'b1;
                m_word[int'(m_fill[3:0])]  = m_fill;
            end
            m_busy = 1'b0;
            m_pend = 1'b0;
        end else if (fl) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRST          = 1'b0;
        bus.PCaddr    = 32'd0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        #1;
        check("rst_iready",   32'(bus.iready),  32'd0);
        check("rst_instr",    bus.instr,        32'd0);
        check("rst_mem_ren",  32'(bus.mem_ren), 32'd0);
        check("rst_mem_addr", bus.mem_addr,     32'd0);
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        @(posedge clk);
        #1 nRST = 1'b1;
    endtask

    logic [31:0] pc, prev_pc;

    initial begin
        bus.PCaddr    = 32'd0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        do_reset();

        // Cold miss, memory answers on the 2nd FILL cycle.
        step(32'h0, 0, 0);
        check("cold_miss_iready", 32'(o_iready), 32'd0);
        check("cold_miss_ren",    32'(o_ren),    32'd0);
        step(32'h0, 0, 0);
        check("cold_fill1_ren",   32'(o_ren),    32'd1);
        check("cold_fill1_addr",  o_addr,        32'h0);
        step(32'h0, 0, 1);
        check("cold_fill2_ren",   32'(o_ren),    32'd1);
        check("cold_fwd_iready",  32'(o_iready), 32'd1);
        check("cold_fwd_instr",   o_instr,       32'h0050_0093);
        step(32'h0, 0, 0);
        check("cold_hit_iready",  32'(o_iready), 32'd1);
        check("cold_hit_instr",   o_instr,       32'h0050_0093);
        check("cold_hit_ren",     32'(o_ren),    32'd0);

        // Conflict eviction: 0x040 shares index 0 with 0x000.
        step(32'h40, 0, 0);
        step(32'h40, 0, 1);
        step(32'h0, 0, 0);
        check("evict_miss_iready", 32'(o_iready), 32'd0);
        step(32'h0, 0, 0);
        check("evict_fill_addr",   o_addr,        32'h0);
        step(32'h0, 0, 1);

        // Flush in the 1st FILL cycle, mem_ready in the 3rd.
        step(32'h8, 0, 0);
        step(32'h8, 1, 0);
        step(32'h8, 0, 0);
        step(32'h8, 0, 1);
        check("flushfill_iready", 32'(o_iready), 32'd0);
        step(32'h8, 0, 0);
        check("flushfill_remiss_iready", 32'(o_iready), 32'd0);
        check("flushfill_remiss_ren",    32'(o_ren),    32'd0);
        step(32'h8, 0, 0);
        check("flushfill_refill_addr",   o_addr,        32'h8);
        step(32'h8, 0, 1);

        // Zero-wait memory: miss completes in exactly 2 cycles.
        step(32'h100, 0, 1);
        check("zw_cycle1_iready", 32'(o_iready), 32'd0);
        step(32'h100, 0, 1);
        check("zw_cycle2_iready", 32'(o_iready), 32'd1);
        check("zw_cycle2_instr",  o_instr,       memfn(30'h40));

        // Flush together with a hit: flush wins.
        step(32'h100, 1, 0);
        check("flush_hit_iready", 32'(o_iready), 32'd0);

        // Stats sequence 0x0, 0x4, 0x0, 0x4, 0x0.
        do_reset();
        step(32'h0, 0, 0);
        step(32'h0, 0, 1);
        step(32'h4, 0, 0);
        step(32'h4, 0, 1);
        step(32'h0, 0, 0);
        step(32'h4, 0, 0);
        step(32'h0, 0, 0);
`ifdef ICACHE_STATS_EN
        #1;
        check("stats_miss_count", miss_count, 32'd2);
        check("stats_hit_count",  hit_count,  32'd3);
`endif

        // Reset asserted mid-fill drops mem_ren at once.
        step(32'h10, 0, 0);
        step(32'h10, 0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("midrst_before_ren", 32'(bus.mem_ren), 32'd1);
        nRST = 1'b0;
        #1;
        check("midrst_ren",  32'(bus.mem_ren),  32'd0);
        check("midrst_addr", bus.mem_addr,      32'd0);
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        @(posedge clk);
        #1 nRST = 1'b1;
        step(32'h0, 0, 0);
        check("midrst_remiss_iready", 32'(o_iready), 32'd0);
        step(32'h0, 0, 0);
        check("midrst_refill_addr",   o_addr,        32'h0);
        step(32'h0, 0, 1);

        // Randomized run over aliasing addresses with flushes and variable memory wait.
        prev_pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                pc = prev_pc;
            end else begin
                pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) pc = pc | 32'h0010_0000;
            end
            prev_pc = pc;
            step(pc, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, single-word-line instruction cache. It is the responder to the PC's fetch request. The cache takes the PC's fetch address (`PCaddr`) and returns the instruction word with `iready`, which gates PC advance. On a miss, it fills from the instruction memory through a ren/ready handshake.

## Interface
Parameters:
- `INDEX_BITS`, 4, log2 of line count (16 lines); index = `PCaddr[INDEX_BITS+1:2]`, tag = `PCaddr[31:INDEX_BITS+2]`

Ports:
- `clk`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `PCaddr`  in  32  fetch address from PC; bits [1:0] ignored
- `flush`  in  1  invalidate all lines
- `iready`  out  1  `instr` valid for `PCaddr` this cycle
- `instr`  out  32  instruction word; 0 when `iready`=0
- `mem_ren`  out  1  backing memory read request
- `mem_addr`  out  32  word-aligned fill address; 0 when `mem_ren`=0
- `mem_rdata`  in  32  backing memory data
- `mem_ready`  in  1  `mem_rdata` valid; completes the request

## Operation
- State machine has two states, IDLE and FILL.
- IDLE:
  - Hit: valid[index] and tag match, with `flush`=0. Drive `iready`=1 combinationally and `instr`=data[index]; stay in IDLE.
  - Miss with `flush`=0: latch `fill_addr`={`PCaddr`[31:2],2'b00} and go to FILL. `iready`=0. `mem_ren` stays 0 in this cycle.
  - `flush`=1: clear all valid bits at the clock edge. `iready`=0 and no miss is started.
- FILL:
  - Drive `mem_ren`=1 and `mem_addr`=`fill_addr`, held stable until `mem_ready`.
  - On `mem_ready`=1 with `flush`=0: write data/tag/valid at the `fill_addr` index, then return to IDLE.
  - Forwarding: if `PCaddr` word-matches `fill_addr`, also drive `iready`=1 and `instr`=`mem_rdata` in that same cycle.
  - `mem_ready`=1 with `flush`=1: discard the data, clear all valid bits, return to IDLE, and keep `iready`=0.
  - `flush`=1 without `mem_ready`: record a pending flush and stay in FILL; the request must complete. On `mem_ready`, discard the data and clear all valid bits.
- Replacement: a fill overwrites the indexed line unconditionally.
- `mem_ready` in IDLE is ignored.

## Timing
- Reset values:
  - State = IDLE, all valid = 0, pending flush = 0.
  - `iready`=0, `instr`=0, `mem_ren`=0, `mem_addr`=0.
  - Tag and data arrays are not reset.
- Hit latency is 0 cycles: `iready` is combinational from `PCaddr`.
- Miss latency is 1 + W cycles, where W is the number of FILL cycles up to and including the `mem_ready` cycle (W ≥ 1).
- `iready` rises in the `mem_ready` cycle.
- `mem_ren` asserts starting the cycle after the miss is detected.
- Reset asserted mid-fill immediately drops `mem_ren`. The memory side must tolerate an abandoned request.
- Simultaneous `flush` and hit in IDLE: the flush wins and `iready`=0.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, each 32 bits and wrapping, both reset to 0.
  - `hit_count` increments on each IDLE hit cycle with `iready`=1. Forwarded fills count as misses only.
  - `miss_count` increments on each IDLE→FILL transition.
- Not defined: these ports and counters are absent, and all other behaviour is identical.

## Structure
- `cpu_pkg` holds the `icache_state_t` enum (`IC_IDLE`, `IC_FILL`) and the word-offset width constant (2).
- Sub-module `icache_store` holds the valid/tag/data arrays:
  - One write port.
  - Combinational read by index.
  - Synchronous flush clearing valid bits.

## Test plan
- Cold miss with 2-cycle memory:
  - Stimulus: reset, `PCaddr`=0x0, `mem_ready` high on the 2nd FILL cycle with `mem_rdata`=0x00500093.
  - Expect: `mem_ren`=1 for 2 cycles with `mem_addr`=0x0; `iready`=1 and `instr`=0x00500093 on the `mem_ready` cycle.
  - Then: re-presenting 0x0 hits with 0 latency.
- Conflict eviction:
  - Stimulus: fill 0x000, then fill 0x040 (same index 0, different tag), then `PCaddr`=0x000.
  - Expect: the final access misses and `mem_addr`=0x000.
- Flush mid-fill:
  - Stimulus: `flush` pulse in the 1st FILL cycle, `mem_ready` in the 3rd.
  - Expect: `iready` stays 0; return to IDLE; the next cycle misses again on the same address.
- Zero-wait memory:
  - Stimulus: `mem_ready` tied high.
  - Expect: a miss takes exactly 2 cycles, with `iready` in the 2nd.
- Stats (`ICACHE_STATS_EN`):
  - Stimulus: fetch sequence 0x0, 0x4, 0x0, 0x4, 0x0.
  - Expect: `miss_count`=2, `hit_count`=3.
- Reset mid-fill:
  - Stimulus: assert `nRST` low during FILL.
  - Expect: `mem_ren`=0 immediately; after release, 0x0 misses again.
